// File: rtl/sk_pkg.sv
// Shared helpers for the pipelined Sklansky add/sub: tree depth, latency and
// placement of the pipeline registers between prefix levels.
package sk_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Cycles from accept to out_valid when the pipe is not stalled.
  function automatic int lat_f(input int w, input int lps);
    int s;
    s = (clog2(w) + lps - 1) / lps;
    return (s < 1) ? 1 : s;
  endfunction

  // A register follows prefix level k (0-based) when it closes a group of
  // lps levels. The last level feeds the output register instead.
  function automatic bit is_reg_level(input int k, input int l, input int lps);
    return ((k + 1) % lps == 0) && (k + 1 < l);
  endfunction

endpackage

// File: rtl/sk_addsub_pipe_cell.sv
// Prefix operator (g,p) o (g',p'). The grey variant is used where the combined
// group already reaches column 0, so its propagate is never consumed.
module sk_gp_cell #(
  parameter bit GREY = 1'b0
) (
  input  logic gi,
  input  logic pi,
  input  logic gj,
  input  logic pj,
  output logic go,
  output logic po
);
  assign go = gi | (pi & gj);
  if (GREY) begin : g_grey
    assign po = 1'b0 & pj;
  end else begin : g_black
    assign po = pi & pj;
  end
endmodule

// File: rtl/sk_addsub_pipe.sv
// Pipelined Sklansky adder/subtractor with a global advance enable.
// Carry-in is folded into column 0 at level 0, so carry into bit i+1 is G[i:0].
module sk_addsub_pipe
  import sk_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int LVL_PER_STG = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int L = clog2(WIDTH);
  localparam int N = 1 << L;

  logic             adv;
  logic [WIDTH-1:0] bb;
  logic             ci0;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign bb       = b ^ {WIDTH{sub}};
  assign ci0      = cin ^ sub;

  // lv[k] holds the inputs to prefix level k; lv[L] feeds the output stage.
  for (genvar k = 0; k <= L; k++) begin : lv
    logic [N-1:0]     g, p;
    logic [WIDTH-1:0] pr;
    logic             c, v;

    if (k == 0) begin : g_src
      for (genvar i = 0; i < N; i++) begin : col
        if (i == 0) begin : g_c0
          assign g[i] = (a[0] & bb[0]) | ((a[0] ^ bb[0]) & ci0);
          assign p[i] = a[0] ^ bb[0];
        end else if (i < WIDTH) begin : g_live
          assign g[i] = a[i] & bb[i];
          assign p[i] = a[i] ^ bb[i];
        end else begin : g_pruned
          assign g[i] = 1'b0;
          assign p[i] = 1'b0;
        end
      end
      assign pr = a ^ bb;
      assign c  = ci0;
      assign v  = in_valid;
    end else begin : g_lvl
      localparam int M = k - 1;
      logic [N-1:0] gc, pc;

      for (genvar i = 0; i < N; i++) begin : col
        localparam int J = ((i >> M) << M) - 1;
        if ((((i >> M) & 1) == 1) && (i < WIDTH)) begin : g_op
          sk_gp_cell #(.GREY(i < (1 << k))) u_cell (
            .gi(lv[k-1].g[i]), .pi(lv[k-1].p[i]),
            .gj(lv[k-1].g[J]), .pj(lv[k-1].p[J]),
            .go(gc[i]),        .po(pc[i])
          );
        end else if (i < WIDTH) begin : g_pass
          assign gc[i] = lv[k-1].g[i];
          assign pc[i] = lv[k-1].p[i];
        end else begin : g_pruned
          assign gc[i] = 1'b0;
          assign pc[i] = 1'b0;
        end
      end

      if (is_reg_level(M, L, LVL_PER_STG)) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            g  <= '0;
            p  <= '0;
            pr <= '0;
            c  <= 1'b0;
            v  <= 1'b0;
          end else if (adv) begin
            g  <= gc;
            p  <= pc;
            pr <= lv[k-1].pr;
            c  <= lv[k-1].c;
            v  <= lv[k-1].v;
          end
        end
      end else begin : g_wire
        assign g  = gc;
        assign p  = pc;
        assign pr = lv[k-1].pr;
        assign c  = lv[k-1].c;
        assign v  = lv[k-1].v;
      end
    end
  end

  logic [WIDTH:0] cy;
  assign cy = {lv[L].g[WIDTH-1:0], lv[L].c};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= lv[L].v;
      sum       <= lv[L].pr ^ cy[WIDTH-1:0];
      cout      <= cy[WIDTH];
      ovf       <= cy[WIDTH] ^ cy[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_sk_addsub_pipe.sv
// Bench for sk_addsub_pipe: three configurations sharing one stimulus bus,
// checked against a plain-arithmetic reference and an expected-result queue.
module tb_sk_addsub_pipe;
  import sk_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] t_a, t_b;
  logic         t_cin, t_sub, t_vld, t_ordy;
  int           sel;

  logic        d64_ir, d64_ov, d64_co, d64_of;
  logic [63:0] d64_s;
  logic        d8_ir, d8_ov, d8_co, d8_of;
  logic [7:0]  d8_s;
  logic        d13_ir, d13_ov, d13_co, d13_of;
  logic [12:0] d13_s;

  sk_addsub_pipe #(.WIDTH(64), .LVL_PER_STG(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_vld && sel == 0), .in_ready(d64_ir),
    .a(t_a[63:0]), .b(t_b[63:0]), .cin(t_cin), .sub(t_sub),
    .out_valid(d64_ov), .out_ready(sel == 0 ? t_ordy : 1'b1),
    .sum(d64_s), .cout(d64_co), .ovf(d64_of));

  sk_addsub_pipe #(.WIDTH(8), .LVL_PER_STG(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_vld && sel == 1), .in_ready(d8_ir),
    .a(t_a[7:0]), .b(t_b[7:0]), .cin(t_cin), .sub(t_sub),
    .out_valid(d8_ov), .out_ready(sel == 1 ? t_ordy : 1'b1),
    .sum(d8_s), .cout(d8_co), .ovf(d8_of));

  sk_addsub_pipe #(.WIDTH(13), .LVL_PER_STG(2)) dut13 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_vld && sel == 2), .in_ready(d13_ir),
    .a(t_a[12:0]), .b(t_b[12:0]), .cin(t_cin), .sub(t_sub),
    .out_valid(d13_ov), .out_ready(sel == 2 ? t_ordy : 1'b1),
    .sum(d13_s), .cout(d13_co), .ovf(d13_of));

  logic         o_rdy, o_valid, o_cout, o_ovf;
  logic [127:0] o_sum;
  always_comb begin
    o_rdy = d64_ir; o_valid = d64_ov; o_cout = d64_co; o_ovf = d64_of;
    o_sum = 128'(d64_s);
    case (sel)
      1: begin o_rdy = d8_ir; o_valid = d8_ov; o_cout = d8_co; o_ovf = d8_of;
               o_sum = 128'(d8_s); end
      2: begin o_rdy = d13_ir; o_valid = d13_ov; o_cout = d13_co; o_ovf = d13_of;
               o_sum = 128'(d13_s); end
      default: ;
    endcase
  end

  int nassert = 0, nfail = 0, cyc = 0, nres = 0, nacc = 0, w_cur = 64, lat_cur = 3;
  bit chk_lat = 1'b0;
  logic [129:0] exq[$];
  int           tq[$];
  logic [129:0] snap;

  task automatic chk(input string tag, input logic [129:0] got, input logic [129:0] exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {ovf, cout, sum} from wide integer arithmetic on the operand values.
  function automatic logic [129:0] ref_f(input int w, input logic [127:0] a,
                                         input logic [127:0] b, input bit cin, input bit sub);
    logic [128:0] mask, av, bv, full, s;
    bit co, of;
    mask = (129'd1 << w) - 129'd1;
    av   = {1'b0, a} & mask;
    bv   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
    full = av + bv + 129'(cin ^ sub);
    s    = full & mask;
    co   = full[w];
    of   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
    return {of, co, s[127:0]};
  endfunction

  task automatic use_dut(input int s);
    sel = s;
    w_cur   = (s == 0) ? 64 : (s == 1) ? 8 : 13;
    lat_cur = (s == 0) ? lat_f(64, 2) : (s == 1) ? lat_f(8, 1) : lat_f(13, 2);
  endtask

  task automatic rnd_ops();
    t_a   = {$urandom, $urandom, $urandom, $urandom};
    t_b   = {$urandom, $urandom, $urandom, $urandom};
    t_cin = 1'($urandom);
    t_sub = 1'($urandom);
  endtask

  // One clock: check any result consumed this cycle, log any beat accepted.
  task automatic step();
    logic [129:0] e;
    #1;
    chk("in_ready", 130'(o_rdy), 130'(!o_valid | t_ordy));
    if (o_valid && t_ordy) begin
      if (exq.size() == 0) chk("extra_result", 130'(1), 130'(0));
      else begin
        e = exq.pop_front();
        chk("result", {o_ovf, o_cout, o_sum}, e);
        if (chk_lat) chk("latency", 130'(cyc - tq[0]), 130'(lat_cur));
        void'(tq.pop_front());
        nres++;
      end
    end
    if (t_vld && o_rdy) begin
      exq.push_back(ref_f(w_cur, t_a, t_b, t_cin, t_sub));
      tq.push_back(cyc);
      nacc++;
    end
    @(posedge clk); @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    t_vld = 1'b0; t_ordy = 1'b1;
    for (int i = 0; i < 40 && exq.size() != 0; i++) step();
    chk("drained", 130'(exq.size()), 130'(0));
    chk("no_loss_dup", 130'(nres), 130'(nacc));
  endtask

  task automatic dir(input string tag, input logic [127:0] a, input logic [127:0] b,
                     input bit cin, input bit sub, input logic [127:0] es,
                     input bit ec, input bit eo);
    int n;
    t_a = a; t_b = b; t_cin = cin; t_sub = sub; t_vld = 1'b1; t_ordy = 1'b1;
    @(posedge clk); @(negedge clk);
    t_vld = 1'b0;
    n = 1;
    while (!o_valid && n < 20) begin @(posedge clk); @(negedge clk); n++; end
    chk({tag, "_lat"}, 130'(n), 130'(lat_cur));
    chk({tag, "_sum"}, 130'(o_sum), 130'(es));
    chk({tag, "_cout"}, 130'(o_cout), 130'(ec));
    chk({tag, "_ovf"}, 130'(o_ovf), 130'(eo));
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    t_a = '0; t_b = '0; t_cin = 1'b0; t_sub = 1'b0; t_vld = 1'b0; t_ordy = 1'b1;
    use_dut(0);
    #1;
    chk("rst_valid", 130'(o_valid), 130'(0));
    chk("rst_sum", 130'(o_sum), 130'(0));
    chk("rst_cout_ovf", 130'({o_cout, o_ovf}), 130'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 130'(o_rdy), 130'(1));

    dir("t1", 128'hFFFF_FFFF_FFFF_FFFF, 128'h0, 1'b1, 1'b0, 128'h0, 1'b1, 1'b0);
    dir("t2a", 128'h0, 128'h1, 1'b0, 1'b1, 128'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    dir("t2b", 128'h8000_0000_0000_0000, 128'h1, 1'b0, 1'b1,
        128'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Back-to-back: one result per cycle, fixed latency.
    nres = 0; nacc = 0; chk_lat = 1'b1; t_ordy = 1'b1;
    for (int i = 0; i < 100; i++) begin rnd_ops(); t_vld = 1'b1; step(); end
    drain();
    chk("b2b_count", 130'(nres), 130'(100));

    // Backpressure: fill, stall five cycles with input still offered.
    chk_lat = 1'b0;
    for (int i = 0; i < 4; i++) begin rnd_ops(); t_vld = 1'b1; step(); end
    t_ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rnd_ops(); t_vld = 1'b1;
      #1;
      if (i == 0) snap = {o_valid, o_ovf, o_cout, o_sum[126:0]};
      else chk("stall_hold", {o_valid, o_ovf, o_cout, o_sum[126:0]}, snap);
      chk("stall_in_ready", 130'(o_rdy), 130'(0));
      step();
    end
    drain();

    // Reset with beats in flight.
    t_ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin rnd_ops(); t_vld = 1'b1; step(); end
    t_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 130'(o_valid), 130'(0));
    chk("midrst_sum", 130'(o_sum), 130'(0));
    exq.delete(); tq.delete(); nres = 0; nacc = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 chk("no_stale", 130'(o_valid), 130'(0));
      step();
    end

    // Narrow configurations: latency check, then random flow control.
    for (int s = 1; s <= 2; s++) begin
      use_dut(s);
      nres = 0; nacc = 0; chk_lat = 1'b1; t_ordy = 1'b1;
      for (int i = 0; i < 20; i++) begin rnd_ops(); t_vld = 1'b1; step(); end
      drain();
      chk_lat = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        rnd_ops();
        t_vld  = ($urandom_range(0, 3) != 0);
        t_ordy = ($urandom_range(0, 3) != 0);
        step();
      end
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
